mac3_sched: RTL and testbench
=============================

# mac3_sched

Two-requester scheduler for the shared a*b+c multiply-accumulate datapath. Each requester submits an operand triplet (a, b, c); the block arbitrates round-robin, streams the triplet into the datapath as three consecutive validi beats, waits for valido, and returns data_out to the winning requester with a one-cycle response pulse. It sits between the two operand sources and the single datapath instance and is that datapath's only driver.

## Interface
- DW, 32, operand and result width
- TIMEOUT, 8, cycles to wait for valido after the c beat before flagging an error (range 2..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[i]=1: requester i has a job pending; held until gnt[i]
- a0, b0, c0  in  DW each  requester 0 operands, stable while req[0]=1
- a1, b1, c1  in  DW each  requester 1 operands, stable while req[1]=1
- gnt  out  2  one-hot pulse, one cycle, operands of winner latched that cycle
- rsp_valid  out  2  one-hot pulse, one cycle, result for requester i
- rsp_data  out  DW  result, meaningful only when any rsp_valid=1, else 0
- rsp_err  out  1  qualifies rsp_valid: 1 = timeout, rsp_data forced 0
- validi  out  1  to datapath: operand beat valid
- data_in  out  DW  to datapath: operand beat
- valido  in  1  from datapath: result valid
- data_out  in  DW  from datapath: result
- proto_err  out  1  sticky: valido seen outside WAIT; cleared only by rst

## Operation
- States: IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP.
- IDLE: if any req, assert gnt to arbiter winner, latch its a/b/c, go SEND_A; else stay.
- SEND_A/B/C: validi=1, data_in = latched a / b / c respectively; advance each cycle, SEND_C -> WAIT.
- WAIT: validi=0, data_in=0. valido=1: capture data_out, go RESP, rsp_err=0. Counter reaches TIMEOUT without valido: go RESP with rsp_err=1, result 0.
- RESP: rsp_valid[winner]=1 with rsp_data/rsp_err; go IDLE.
- Arbitration: round-robin pointer; last-granted requester loses ties. Reset value of pointer = 1, so requester 0 wins first simultaneous request. Single requester always wins regardless of pointer.
- A requester holding req through RESP is eligible again in the next IDLE.
- validi is never high for more than three consecutive cycles; at least three validi=0 cycles (WAIT min, RESP, IDLE) separate jobs, so the datapath's three-beat window never spans two jobs.
- Arithmetic is the datapath's; result passed through unmodified, modulo 2^DW.
- valido in any state other than WAIT sets proto_err; it does not disturb the FSM.

## Timing
- Reset (async assert, sync-safe release): state IDLE, pointer=1, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, validi=0, data_in=0, proto_err=0, timeout counter=0.
- Grant at cycle T; validi=1 at T+1 (a), T+2 (b), T+3 (c); nominal valido at T+4; rsp_valid at T+5; next gnt earliest T+6.
- Job latency req-to-rsp: 6 cycles nominal (req already high in IDLE at T), throughput one job per 6 cycles.
- Timeout: WAIT counter starts at T+4; with no valido, RESP at T+4+TIMEOUT.
- Reset mid-job: in-flight job discarded, no rsp_valid issued; requester must re-request.
- gnt, rsp_valid, validi, data_in all registered outputs.

## Structure
- Package mac3_sched_pkg: state enum, DW and TIMEOUT defaults, requester-index type.
- Sub-module rr_arb2: two-way round-robin arbiter (req[1:0], advance, gnt one-hot, pointer register).
- Top holds FSM, operand latches, timeout counter, result register, proto_err flag.

## Test plan
- Reset then req=01, a0=3, b0=4, c0=5, datapath model returns 17 at T+4 -> gnt=01 at T, validi beats 3,4,5 at T+1..T+3, rsp_valid=01 rsp_data=17 rsp_err=0 at T+5.
- req=11 held for three jobs -> grants 01, 10, 01 in order, spaced 6 cycles, each validi burst exactly 3 cycles.
- a1=32'hFFFF_FFFF, b1=2, c1=1, model returns 32'hFFFF_FFFF -> rsp_data=32'hFFFF_FFFF (wrap preserved).
- Model never asserts valido, TIMEOUT=8 -> rsp_valid at T+12 with rsp_err=1, rsp_data=0; next job proceeds normally.
- valido pulsed during IDLE -> proto_err=1 and stays 1; FSM unaffected; cleared only by rst.
- rst asserted at T+2 mid-job -> all outputs 0 asynchronously, no rsp_valid; after release with req=11, requester 0 granted first.

Source files
------------

// File: rtl/mac3_sched_pkg.sv
// mac3_sched_pkg
// Shared types and defaults for the two-requester a*b+c scheduler:
//   - FSM state encoding used by mac3_sched
//   - default operand width and valido timeout
//   - requester index type plus a helper turning an index into a one-hot pair
package mac3_sched_pkg;

  localparam int DW_DEFAULT      = 32;
  localparam int TIMEOUT_DEFAULT = 8;

  // Wide enough for any legal TIMEOUT (2..255).
  localparam int TO_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_C,
    WAIT,
    RESP
  } state_t;

  typedef logic reqIdx_t;

  function automatic logic [1:0] idxToOneHot(input reqIdx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mac3_sched_arb.sv
// rr_arb2
// Two-way round-robin arbiter. Holds a pointer to the last granted requester;
// on a tie the pointed-to requester loses. A lone requester always wins.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (pointer resets to 1)
//   req_i      pending requests
//   advance_i  winner is being granted this cycle: move pointer to it
//   gnt_o      combinational one-hot winner (0 when no request)
module rr_arb2
  import mac3_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  reqIdx_t ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      ptr_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/mac3_sched.sv
// mac3_sched
// Schedules jobs from two operand sources onto one shared a*b+c datapath.
// A granted triplet is streamed as three validi beats (a, b, c), the block
// waits for valido (or a timeout), then pulses rsp_valid to the winner.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req[1:0]             job pending per requester, held until gnt
//   a0/b0/c0, a1/b1/c1   operand triplets, stable while req is high
//   gnt[1:0]             one-hot grant pulse
//   rsp_valid[1:0]       one-hot response pulse
//   rsp_data, rsp_err    response payload (0 outside the pulse)
//   validi, data_in      operand beats to the datapath
//   valido, data_out     result from the datapath
//   proto_err            sticky: valido arrived while not waiting for it
module mac3_sched
  import mac3_sched_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] c0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] c1,
  output logic [1:0]    gnt,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          validi,
  output logic [DW-1:0] data_in,
  input  logic          valido,
  input  logic [DW-1:0] data_out,
  output logic          proto_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [TO_CNT_W-1:0] CNT_ONE = TO_CNT_W'(1);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rspValid_q, rspValid_d;
  logic [DW-1:0]       rspData_q, rspData_d;
  logic                rspErr_q, rspErr_d;
  logic                validi_q, validi_d;
  logic [DW-1:0]       dataIn_q, dataIn_d;
  logic                protoErr_q, protoErr_d;
  logic [TO_CNT_W-1:0] toCnt_q, toCnt_d;
  logic [DW-1:0]       opA_q, opB_q, opC_q;
  reqIdx_t             winner_q;

  logic [1:0]          arbGnt;
  logic                arbAdvance;

  rr_arb2 uArb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .advance_i (arbAdvance),
    .gnt_o     (arbGnt)
  );

  // Grants are decided on the edge entering an IDLE cycle (from IDLE or
  // RESP), so gnt is a register and still lines up with IDLE. An IDLE cycle
  // that already shows a grant moves on to the a beat.
  always_comb begin
    state_d    = state_q;
    gnt_d      = 2'b00;
    arbAdvance = 1'b0;
    rspValid_d = 2'b00;
    rspData_d  = '0;
    rspErr_d   = 1'b0;
    toCnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_q != 2'b00) begin
          state_d = SEND_A;
        end else if (req != 2'b00) begin
          gnt_d      = arbGnt;
          arbAdvance = 1'b1;
        end
      end
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = SEND_C;
      SEND_C: state_d = WAIT;
      WAIT: begin
        if (valido) begin
          state_d    = RESP;
          rspValid_d = idxToOneHot(winner_q);
          rspData_d  = data_out;
        end else if (toCnt_q == TO_LAST) begin
          state_d    = RESP;
          rspValid_d = idxToOneHot(winner_q);
          rspErr_d   = 1'b1;
        end else begin
          toCnt_d = toCnt_q + CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (req != 2'b00) begin
          gnt_d      = arbGnt;
          arbAdvance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats are decoded from the next state so validi/data_in are registered
  // yet appear in the same cycle as SEND_A/B/C.
  always_comb begin
    validi_d = 1'b0;
    dataIn_d = '0;
    case (state_d)
      SEND_A: begin validi_d = 1'b1; dataIn_d = opA_q; end
      SEND_B: begin validi_d = 1'b1; dataIn_d = opB_q; end
      SEND_C: begin validi_d = 1'b1; dataIn_d = opC_q; end
      default: begin validi_d = 1'b0; dataIn_d = '0; end
    endcase
  end

  assign protoErr_d = protoErr_q | (valido && (state_q != WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      rspValid_q <= 2'b00;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
      validi_q   <= 1'b0;
      dataIn_q   <= '0;
      protoErr_q <= 1'b0;
      toCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
      validi_q   <= validi_d;
      dataIn_q   <= dataIn_d;
      protoErr_q <= protoErr_d;
      toCnt_q    <= toCnt_d;
    end
  end

  // Winner's operands are captured together with its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      opC_q    <= '0;
    end else if (gnt_d != 2'b00) begin
      winner_q <= gnt_d[1];
      opA_q    <= gnt_d[1] ? a1 : a0;
      opB_q    <= gnt_d[1] ? b1 : b0;
      opC_q    <= gnt_d[1] ? c1 : c0;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_err   = rspErr_q;
  assign validi    = validi_q;
  assign data_in   = dataIn_q;
  assign proto_err = protoErr_q;

endmodule

// File: tb/tb_mac3_sched.sv
// tb_mac3_sched
// Drives two requesters and a datapath stand-in, and predicts every output
// every cycle from a job-level model: grant cycle T, beats at T+1..T+3,
// response one cycle after valido (or at T+4+TIMEOUT), next grant only
// after the response cycle.
module tb_mac3_sched;

  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [DW-1:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
  logic [1:0]    gnt, rsp_valid;
  logic [DW-1:0] rsp_data, data_in;
  logic          rsp_err, validi, proto_err;
  logic          valido = 1'b0;
  logic [DW-1:0] data_out = '0;

  mac3_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .c0        (c0),
    .a1        (a1),
    .b1        (b1),
    .c1        (c1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .validi    (validi),
    .data_in   (data_in),
    .valido    (valido),
    .data_out  (data_out),
    .proto_err (proto_err)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;
  int cycle       = 0;

  logic [31:0] opsReg [2][3];
  logic [31:0] prevOps[2][3];
  logic [1:0]  prevReq = 2'b00;

  int holdMode   = 2;
  bit raiseEn    = 1'b0;
  bit strayEn    = 1'b0;
  int forceDelay = 0;

  bit          jobActive = 1'b0;
  int          jobT, jobResp, jobDelay;
  bit          jobWinner, jobErr;
  logic [31:0] jobOps[3];
  logic [31:0] jobResult;
  bit          lastWinner  = 1'b1;
  bit          canGrantPrev = 1'b1;
  bit          protoExp    = 1'b0;
  bit          strayPrev   = 1'b0;

  logic [31:0] beats[$];
  logic [31:0] dpResult = '0;
  int          valTime  = -1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h, want %0h", tag, cycle, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    a0 = opsReg[0][0]; b0 = opsReg[0][1]; c0 = opsReg[0][2];
    a1 = opsReg[1][0]; b1 = opsReg[1][1]; c1 = opsReg[1][2];
    prevReq = req;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) prevOps[i][k] = opsReg[i][k];
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    v = $urandom();
    if ($urandom_range(0, 7) == 0) v = 32'hFFFF_FFFF;
    return v;
  endfunction

  function automatic int pickDelay();
    int r;
    if (forceDelay != -2) return forceDelay;
    r = $urandom_range(0, 9);
    if (r <= 5) return 0;
    if (r <= 7) return $urandom_range(1, TIMEOUT - 2);
    if (r == 8) return TIMEOUT - 1;
    return -1;
  endfunction

  task automatic newJob(input int i);
    req[i] = 1'b1;
    for (int k = 0; k < 3; k++) opsReg[i][k] = randOperand();
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
    req[i] = 1'b1;
    opsReg[i][0] = a; opsReg[i][1] = b; opsReg[i][2] = c;
    applyStimulus();
  endtask

  task automatic stepCycle();
    logic [1:0]  expGnt, expRspValid;
    logic        expValidi, expRspErr;
    logic [31:0] expData, expRspData;
    bit          w, stray;
    @(posedge clk);
    #1;
    cycle++;
    if (strayPrev) protoExp = 1'b1;

    expGnt = 2'b00;
    if (canGrantPrev && prevReq != 2'b00) begin
      w = (prevReq == 2'b11) ? ~lastWinner : prevReq[1];
      expGnt     = w ? 2'b10 : 2'b01;
      lastWinner = w;
      jobActive  = 1'b1;
      jobT       = cycle;
      jobWinner  = w;
      for (int k = 0; k < 3; k++) jobOps[k] = prevOps[w][k];
      jobResult  = jobOps[0] * jobOps[1] + jobOps[2];
      jobDelay   = pickDelay();
      jobErr     = (jobDelay < 0);
      jobResp    = jobErr ? cycle + 4 + TIMEOUT : cycle + 5 + jobDelay;
    end

    expValidi = 1'b0;
    expData   = '0;
    if (jobActive && cycle > jobT && cycle <= jobT + 3) begin
      expValidi = 1'b1;
      expData   = jobOps[cycle - jobT - 1];
    end

    expRspValid = 2'b00;
    expRspData  = '0;
    expRspErr   = 1'b0;
    if (jobActive && cycle == jobResp) begin
      expRspValid = jobWinner ? 2'b10 : 2'b01;
      expRspErr   = jobErr;
      expRspData  = jobErr ? 32'h0 : jobResult;
    end

    checkOutput("gnt",       {30'b0, gnt},       {30'b0, expGnt});
    checkOutput("validi",    {31'b0, validi},    {31'b0, expValidi});
    checkOutput("data_in",   data_in,            expData);
    checkOutput("rsp_valid", {30'b0, rsp_valid}, {30'b0, expRspValid});
    checkOutput("rsp_data",  rsp_data,           expRspData);
    checkOutput("rsp_err",   {31'b0, rsp_err},   {31'b0, expRspErr});
    checkOutput("proto_err", {31'b0, proto_err}, {31'b0, protoExp});

    canGrantPrev = !jobActive || (cycle == jobResp);
    if (jobActive && cycle == jobResp) jobActive = 1'b0;

    if (validi) begin
      beats.push_back(data_in);
      if (beats.size() == 3) begin
        dpResult = beats[0] * beats[1] + beats[2];
        beats.delete();
        valTime  = (jobDelay < 0) ? -1 : cycle + 1 + jobDelay;
      end
    end

    valido   = 1'b0;
    data_out = $urandom();
    stray    = 1'b0;
    if (valTime == cycle) begin
      valido   = 1'b1;
      data_out = dpResult;
      valTime  = -1;
    end else if (strayEn && !jobActive && $urandom_range(0, 199) == 0) begin
      valido = 1'b1;
      stray  = 1'b1;
    end
    strayPrev = stray;

    for (int i = 0; i < 2; i++) begin
      if (req[i] && gnt[i]) begin
        if (holdMode == 2 || (holdMode == 0 && $urandom_range(0, 1) == 0)) req[i] = 1'b0;
      end else if (!req[i] && raiseEn && $urandom_range(0, 3) == 0) begin
        newJob(i);
      end
    end
    applyStimulus();
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic runUntilGrant();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      stepCycle();
      if (gnt != 2'b00) seen = 1'b1;
    end
    checkOutput("grant_seen", {31'b0, seen}, 32'd1);
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic doReset(input bit forceBoth);
    rst = 1'b1;
    #1;
    checkOutput("rst_gnt",       {30'b0, gnt},       32'd0);
    checkOutput("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data",  rsp_data,           32'd0);
    checkOutput("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    checkOutput("rst_validi",    {31'b0, validi},    32'd0);
    checkOutput("rst_data_in",   data_in,            32'd0);
    checkOutput("rst_proto_err", {31'b0, proto_err}, 32'd0);
    jobActive    = 1'b0;
    lastWinner   = 1'b1;
    protoExp     = 1'b0;
    canGrantPrev = 1'b1;
    strayPrev    = 1'b0;
    valTime      = -1;
    beats.delete();
    valido = 1'b0;
    if (forceBoth) begin
      newJob(0);
      newJob(1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus();
  endtask

  // Directed scenarios first, then a long randomized run with resets.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) opsReg[i][k] = '0;
    #2;
    doReset(1'b0);

    setReq(0, 32'd3, 32'd4, 32'd5);
    runCycles(8);

    holdMode = 1;
    setReq(0, randOperand(), randOperand(), randOperand());
    setReq(1, 32'hFFFF_FFFF, 32'd2, 32'd1);
    runCycles(18);
    holdMode = 2;
    runCycles(14);

    forceDelay = -1;
    setReq(0, randOperand(), randOperand(), randOperand());
    runCycles(2);
    forceDelay = 0;
    runCycles(14);
    setReq(1, randOperand(), randOperand(), randOperand());
    runCycles(8);

    if (!jobActive) begin
      valido    = 1'b1;
      strayPrev = 1'b1;
    end
    runCycles(3);
    setReq(0, randOperand(), randOperand(), randOperand());
    runCycles(8);

    setReq(0, randOperand(), randOperand(), randOperand());
    runUntilGrant();
    runCycles(2);
    doReset(1'b1);
    runCycles(8);

    raiseEn    = 1'b1;
    holdMode   = 0;
    strayEn    = 1'b1;
    forceDelay = -2;
    for (int r = 0; r < 4; r++) begin
      runCycles(700);
      doReset(r[0]);
    end
    raiseEn = 1'b0;
    runCycles(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
